// File: rtl/hps_download_router.sv
// Packs the HPS ioctl byte stream into DATA_W words and routes them to one of REGIONS memory targets.
// A single output register holds one pending word; a blocked push raises ioctl_wait on the next cycle.
module hps_download_router #(
  parameter  int REGIONS    = 4,
  parameter  int ADDR_W     = 25,
  parameter  int DATA_W     = 16,
  parameter  int RESET_HOLD = 16,
  localparam int BYTES      = DATA_W / 8,
  localparam int LB         = $clog2(BYTES)
) (
  input  logic                   i_clk_sys,
  input  logic                   i_reset,
  input  logic                   i_ioctl_download,
  input  logic [7:0]             i_ioctl_index,
  input  logic                   i_ioctl_wr,
  input  logic [ADDR_W-1:0]      i_ioctl_addr,
  input  logic [7:0]             i_ioctl_dout,
  output logic                   o_ioctl_wait,
  output logic [REGIONS-1:0]     o_mem_wr,
  output logic [ADDR_W-LB-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]      o_mem_din,
  output logic [BYTES-1:0]       o_mem_be,
  input  logic                   i_mem_ready,
  output logic                   o_core_reset,
  output logic [REGIONS-1:0]     o_dl_done,
  output logic                   o_dl_error
);

  localparam int LBW = (LB > 0) ? LB : 1;
  localparam int WAW = ADDR_W - LB;
  localparam int RW  = (REGIONS > 1) ? $clog2(REGIONS) : 1;
  localparam int CW  = $clog2(RESET_HOLD + 2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [RW-1:0]      r_region;
  logic               r_invalid;
  logic               r_dl_prev;
  logic [REGIONS-1:0] r_dl_done;
  logic               r_dl_error;

  logic [DATA_W-1:0]  r_asm_data, n_asm_data;
  logic [BYTES-1:0]   r_asm_be, n_asm_be;
  logic [WAW-1:0]     r_asm_waddr, n_asm_waddr;
  logic               r_asm_vld, n_asm_vld;
  logic               r_asm_full, n_asm_full;
  logic               r_hold_vld, n_hold_vld;
  logic [ADDR_W-1:0]  r_hold_addr, n_hold_addr;
  logic [7:0]         r_hold_dat, n_hold_dat;
  logic               r_wait, n_wait;
  logic [REGIONS-1:0] r_mem_wr, n_mem_wr;
  logic [WAW-1:0]     r_mem_addr, n_mem_addr;
  logic [DATA_W-1:0]  r_mem_din, n_mem_din;
  logic [BYTES-1:0]   r_mem_be, n_mem_be;

  logic               w_dl_rise;
  logic               w_idx_bad;
  logic               w_wr_new;
  logic               w_in_vld;
  logic [ADDR_W-1:0]  w_in_addr;
  logic [7:0]         w_in_dat;
  logic [WAW-1:0]     w_in_waddr;
  logic [LBW-1:0]     w_in_lane;
  logic               w_accept;
  logic [REGIONS-1:0] w_region_oh;
  logic               w_drain_done;
  logic               w_free;
  logic               w_push_old;

  assign w_dl_rise    = i_ioctl_download & ~r_dl_prev;
  assign w_idx_bad    = 32'(i_ioctl_index) >= REGIONS;
  assign w_wr_new     = (r_state == S_COLLECT) & i_ioctl_download & i_ioctl_wr &
                        ~r_invalid & ~r_wait & ~r_hold_vld;
  // A byte that arrives in the same cycle its predecessor word gets blocked is parked in r_hold_*.
  assign w_in_vld     = r_hold_vld | w_wr_new;
  assign w_in_addr    = r_hold_vld ? r_hold_addr : i_ioctl_addr;
  assign w_in_dat     = r_hold_vld ? r_hold_dat : i_ioctl_dout;
  assign w_in_waddr   = w_in_addr[ADDR_W-1:LB];
  assign w_in_lane    = (LB > 0) ? w_in_addr[LBW-1:0] : '0;
  assign w_accept     = (|r_mem_wr) & i_mem_ready;
  assign w_region_oh  = REGIONS'(1) << r_region;
  assign w_drain_done = (r_state == S_DRAIN) & ~r_asm_vld & ~r_hold_vld & ~(|r_mem_wr);

  always_comb begin
    n_asm_data  = r_asm_data;
    n_asm_be    = r_asm_be;
    n_asm_waddr = r_asm_waddr;
    n_asm_vld   = r_asm_vld;
    n_asm_full  = r_asm_full;
    n_hold_vld  = r_hold_vld;
    n_hold_addr = r_hold_addr;
    n_hold_dat  = r_hold_dat;
    n_wait      = 1'b0;
    n_mem_wr    = w_accept ? '0 : r_mem_wr;
    n_mem_addr  = r_mem_addr;
    n_mem_din   = r_mem_din;
    n_mem_be    = r_mem_be;
    w_free      = ~(|r_mem_wr) | i_mem_ready;
    w_push_old  = r_asm_vld & (r_asm_full | (r_state == S_DRAIN) |
                               (w_in_vld & (w_in_waddr != r_asm_waddr)));

    if (w_push_old) begin
      if (w_free) begin
        n_mem_wr    = w_region_oh;
        n_mem_addr  = r_asm_waddr;
        n_mem_din   = r_asm_data;
        n_mem_be    = r_asm_be;
        n_asm_data  = '0;
        n_asm_be    = '0;
        n_asm_vld   = 1'b0;
        n_asm_full  = 1'b0;
        w_free      = 1'b0;
      end else begin
        n_wait = 1'b1;
      end
    end

    if (w_in_vld && !n_asm_vld) begin
      n_asm_data  = '0;
      n_asm_be    = '0;
      n_asm_waddr = w_in_waddr;
      n_asm_vld   = 1'b1;
    end

    if (w_in_vld && n_asm_waddr == w_in_waddr && !n_asm_full) begin
      n_asm_data[{w_in_lane, 3'b000} +: 8] = w_in_dat;
      n_asm_be[w_in_lane]                  = 1'b1;
      n_hold_vld                           = 1'b0;
      if (w_in_lane == LBW'(BYTES - 1)) begin
        if (w_free) begin
          n_mem_wr    = w_region_oh;
          n_mem_addr  = n_asm_waddr;
          n_mem_din   = n_asm_data;
          n_mem_be    = n_asm_be;
          n_asm_data  = '0;
          n_asm_be    = '0;
          n_asm_vld   = 1'b0;
        end else begin
          n_asm_full  = 1'b1;
          n_wait      = 1'b1;
        end
      end
    end else if (w_wr_new) begin
      n_hold_vld  = 1'b1;
      n_hold_addr = i_ioctl_addr;
      n_hold_dat  = i_ioctl_dout;
    end
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_asm_data  <= '0;
      r_asm_be    <= '0;
      r_asm_waddr <= '0;
      r_asm_vld   <= 1'b0;
      r_asm_full  <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_addr <= '0;
      r_hold_dat  <= '0;
      r_wait      <= 1'b0;
      r_mem_wr    <= '0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_be    <= '0;
    end else begin
      r_asm_data  <= n_asm_data;
      r_asm_be    <= n_asm_be;
      r_asm_waddr <= n_asm_waddr;
      r_asm_vld   <= n_asm_vld;
      r_asm_full  <= n_asm_full;
      r_hold_vld  <= n_hold_vld;
      r_hold_addr <= n_hold_addr;
      r_hold_dat  <= n_hold_dat;
      r_wait      <= n_wait;
      r_mem_wr    <= n_mem_wr;
      r_mem_addr  <= n_mem_addr;
      r_mem_din   <= n_mem_din;
      r_mem_be    <= n_mem_be;
    end
  end

  // r_dl_prev resets high so a download still running across reset is not taken as a new session.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_HOLD;
      r_cnt      <= CW'(RESET_HOLD);
      r_region   <= '0;
      r_invalid  <= 1'b0;
      r_dl_prev  <= 1'b1;
      r_dl_done  <= '0;
      r_dl_error <= 1'b0;
    end else begin
      r_dl_prev <= i_ioctl_download;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_dl_rise) begin
            r_region  <= i_ioctl_index[RW-1:0];
            r_invalid <= w_idx_bad;
            if (w_idx_bad) r_dl_error <= 1'b1;
            r_state   <= S_COLLECT;
          end else if (r_state == S_HOLD) begin
            if (r_cnt <= CW'(1)) r_state <= S_IDLE;
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          end
        end
        S_COLLECT: begin
          if (!i_ioctl_download) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            if (!r_invalid) r_dl_done <= r_dl_done | w_region_oh;
            r_cnt   <= CW'(RESET_HOLD);
            r_state <= S_HOLD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ioctl_wait = r_wait;
  assign o_mem_wr     = r_mem_wr;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_din    = r_mem_din;
  assign o_mem_be     = r_mem_be;
  assign o_core_reset = (r_state == S_IDLE) ? i_ioctl_download : 1'b1;
  assign o_dl_done    = r_dl_done;
  assign o_dl_error   = r_dl_error;

endmodule

// File: doc/hps_download_router.md
Name: hps_download_router

Overview:
- Receives the HPS ioctl byte stream and packs the bytes into DATA_W-wide words.
- Routes each word to one of REGIONS memory targets (ROM banks, cartridge, disk image), selected by ioctl_index.
- Generalises the single-target ROM loader in the top-level wrapper: multiple regions, configurable word width, byte enables, backpressure via ioctl_wait, and a core-reset hold that spans the download.
- Sits between hps_io and the core's memories on clk_sys.

Parameters:
- REGIONS, 4, number of download targets; ioctl_index values 0..REGIONS-1 are valid.
- ADDR_W, 25, ioctl byte-address width.
- DATA_W, 16, output word width; must be 8, 16, 32 or 64. BYTES = DATA_W/8, LB = log2(BYTES).
- RESET_HOLD, 16, number of clk_sys cycles core_reset stays high after a download completes or after reset.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  high for the duration of a download.
- ioctl_index  in  8  target region select; sampled on the rising edge of ioctl_download.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  ADDR_W  byte address within the region.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  backpressure to hps_io.
- mem_wr  out  REGIONS  one-hot write request; held until accepted.
- mem_addr  out  ADDR_W-LB  word address.
- mem_din  out  DATA_W  word data; byte lane i = bits [8i+7:8i].
- mem_be  out  BYTES  byte enables for mem_din.
- mem_ready  in  1  shared accept; a transfer completes on any cycle where mem_wr!=0 && mem_ready.
- core_reset  out  1  holds the emulated machine in reset.
- dl_done  out  REGIONS  sticky per region; set when a download to that region completes.
- dl_error  out  1  sticky; set by a download with an invalid index.

Behaviour:
- Reset values: ioctl_wait=0, mem_wr=0, mem_addr=0, mem_din=0, mem_be=0, core_reset=1, dl_done=0, dl_error=0. The FSM enters HOLD with its counter loaded to RESET_HOLD.
- Clocking: clk_sys only. reset is asynchronous and active-high. All other inputs are already synchronous to clk_sys.
- Storage: an assembly register (asm_data, asm_be, asm_waddr, asm_valid) and an output register (mem_*). At most one word is pending at the output.
- FSM states: IDLE, COLLECT, DRAIN, HOLD.
- IDLE:
  - core_reset follows ioctl_download.
  - On ioctl_download rising: latch region = ioctl_index. If index >= REGIONS, set dl_error and mark the session invalid.
  - Go to COLLECT.
- COLLECT (core_reset=1):
  - On ioctl_wr, compute waddr = ioctl_addr[ADDR_W-1:LB] and lane = ioctl_addr[LB-1:0].
  - If asm_valid and waddr != asm_waddr, the assembly word is first pushed to the output; the new byte then starts a fresh assembly word.
  - Store the byte in its lane and set asm_be[lane].
  - If lane==BYTES-1, push the word on the same cycle the byte is stored.
  - Rewriting the same lane overwrites it (last write wins).
  - Invalid session: bytes are discarded; mem_wr is never asserted.
- Push rules:
  - Output free (mem_wr==0, or mem_ready this cycle): load mem_addr/mem_din/mem_be, set mem_wr[region]=1, and clear the assembly.
  - Output busy: assert ioctl_wait and keep the assembly until the output frees. hps_io issues no ioctl_wr while ioctl_wait=1; any strobe received during ioctl_wait is a protocol violation and is dropped.
  - ioctl_wait is registered: it goes high on the cycle after a blocked push is detected and goes low on the cycle after the push completes.
- Falling edge of ioctl_download in COLLECT: go to DRAIN.
- DRAIN:
  - Push any partial assembly word with its partial mem_be.
  - Wait until the output is empty (mem_wr==0).
  - Then set dl_done[region] (valid sessions only), load the counter with RESET_HOLD, and go to HOLD.
- HOLD:
  - core_reset=1; the counter decrements each cycle.
  - At 0, go to IDLE; core_reset deasserts on the following cycle.
  - A new ioctl_download rising edge in HOLD goes directly to COLLECT.
- mem_* stability: mem_addr, mem_din and mem_be are stable while mem_wr!=0. mem_wr drops on the cycle after acceptance unless a new word is loaded that same cycle (back-to-back transfers allowed).
- dl_done and dl_error clear only on reset. A new download to the same region leaves its dl_done bit at 1.
- Reset mid-download: all state is discarded, no further mem_wr is issued, and the block restarts in HOLD.
- Address wrap: ioctl_addr wraps modulo 2^ADDR_W with no special handling.

Test Plan:
- Reset release -> core_reset=1 for 16 cycles, then 0; mem_wr=0 throughout.
- DATA_W=16, index 1, bytes 0x11@0, 0x22@1, mem_ready=1 -> one transfer: mem_wr=4'b0010, mem_addr=0, mem_din=16'h2211, mem_be=2'b11; then dl_done=4'b0010 after download end.
- Odd-length download: 3 bytes at 0..2, then ioctl_download falls -> second transfer has mem_addr=1, mem_din[7:0]=byte2, mem_be=2'b01, issued in DRAIN.
- Non-sequential address: bytes @4 then @9 -> two transfers: waddr 2 with be=2'b01, then waddr 4 with be=2'b10.
- mem_ready held 0 for 20 cycles during streaming -> ioctl_wait=1 within 1 cycle of the blocked push; mem_addr/mem_din/mem_be stable for all 20 cycles; no bytes lost after mem_ready returns.
- index=7 with REGIONS=4 -> mem_wr never asserted, dl_error=1, core_reset held through the download plus 16 cycles; assert reset mid-download -> mem_wr=0 immediately and core_reset=1.
